// File: rtl/logic_unit_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_sweeper
// Description : Drives every (select, a, b) combination into the shared logic
//               unit, samples its output after a settle time and assembles a
//               32-bit truth table.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_sweeper #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        lu_s,
    output logic        lu_a,
    output logic        lu_b,
    output logic [2:0]  lu_select,
    output logic        busy,
    output logic        done,
    output logic [4:0]  step,
    output logic [31:0] table_out
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_drive = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [3:0] c_settle    = 4'(SETTLE);
    localparam logic [4:0] c_last_step = 5'd31;

    logic [1:0]  r_state;
    logic [4:0]  r_step;
    logic [3:0]  r_cnt;
    logic [31:0] r_table;
    logic        r_busy;
    logic        r_done;

    logic [1:0]  w_next_state;
    logic [4:0]  w_next_step;
    logic [3:0]  w_next_cnt;
    logic [31:0] w_next_table;

    always_comb begin
        w_next_state = r_state;
        w_next_step  = r_step;
        w_next_cnt   = r_cnt;
        w_next_table = r_table;
        case (r_state)
            c_st_idle: begin
                if (start && !abort) begin
                    w_next_state = c_st_drive;
                    w_next_step  = 5'd0;
                    w_next_cnt   = 4'd0;
                    w_next_table = 32'd0;
                end
            end
            c_st_drive: begin
                // Abort wins over a sample due on the same edge.
                if (abort) begin
                    w_next_state = c_st_idle;
                end else if (r_cnt == c_settle) begin
                    w_next_table[r_step] = lu_s;
                    w_next_cnt           = 4'd0;
                    if (r_step == c_last_step) begin
                        w_next_state = c_st_done;
                    end else begin
                        w_next_step = r_step + 5'd1;
                    end
                end else begin
                    w_next_cnt = r_cnt + 4'd1;
                end
            end
            c_st_done: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // busy/done are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_step  <= 5'd0;
            r_cnt   <= 4'd0;
            r_table <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_step  <= w_next_step;
            r_cnt   <= w_next_cnt;
            r_table <= w_next_table;
            r_busy  <= (w_next_state == c_st_drive);
            r_done  <= (w_next_state == c_st_done);
        end
    end

    assign lu_select = r_step[4:2];
    assign lu_a      = r_step[1];
    assign lu_b      = r_step[0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign step      = r_step;
    assign table_out = r_table;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_sweeper
// Description : Directed bench for logic_unit_sweeper with SETTLE = 1, 0, 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_sweeper;

    localparam logic [31:0] c_gold = 32'h9678_1E53;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   lu_mode = 0;

    logic start1 = 1'b0, abort1 = 1'b0, start0 = 1'b0, start3 = 1'b0;
    logic zero = 1'b0;

    wire        lu_s1, lu_a1, lu_b1, busy1, done1;
    wire [2:0]  sel1;
    wire [4:0]  step1;
    wire [31:0] table1;
    wire        lu_s0, lu_a0, lu_b0, busy0, done0;
    wire [2:0]  sel0;
    wire [4:0]  step0;
    wire [31:0] table0;
    wire        lu_s3, lu_a3, lu_b3, busy3, done3;
    wire [2:0]  sel3;
    wire [4:0]  step3;
    wire [31:0] table3;

    function automatic logic unit_model(input logic [2:0] s, input logic a, input logic b);
        case (s)
            3'd0:    return ~a;
            3'd1:    return ~b;
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a & b;
            3'd5:    return ~(a & b);
            3'd6:    return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    assign lu_s1 = (lu_mode == 0) ? unit_model(sel1, lu_a1, lu_b1) : (lu_mode == 2);
    assign lu_s0 = unit_model(sel0, lu_a0, lu_b0);
    assign lu_s3 = unit_model(sel3, lu_a3, lu_b3);

    logic_unit_sweeper #(.SETTLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1), .lu_s(lu_s1),
        .lu_a(lu_a1), .lu_b(lu_b1), .lu_select(sel1), .busy(busy1), .done(done1),
        .step(step1), .table_out(table1));

    logic_unit_sweeper #(.SETTLE(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(zero), .lu_s(lu_s0),
        .lu_a(lu_a0), .lu_b(lu_b0), .lu_select(sel0), .busy(busy0), .done(done0),
        .step(step0), .table_out(table0));

    logic_unit_sweeper #(.SETTLE(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .abort(zero), .lu_s(lu_s3),
        .lu_a(lu_a3), .lu_b(lu_b3), .lu_select(sel3), .busy(busy3), .done(done3),
        .step(step3), .table_out(table3));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves time just after edge E0.
    task automatic start_sweep1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
    endtask

    // n = edges after E0 until done is seen (-1 on timeout); busy_n = busy samples.
    task automatic wait_done1(output int n, output int busy_n);
        n = 0;
        busy_n = busy1 ? 1 : 0;
        while (!done1 && n < 300) begin
            tick();
            n++;
            if (busy1) busy_n++;
        end
        if (!done1) n = -1;
    endtask

    task automatic wait_step1(input logic [4:0] tgt, output int n);
        n = 0;
        while (step1 !== tgt && n < 300) begin
            tick();
            n++;
        end
        if (step1 !== tgt) n = -1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy1, done1, step1, table1, sel1, lu_a1, lu_b1} !== 43'd0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b step=%0d table=%h sel=%0d a=%b b=%b, want all 0",
                     busy1, done1, step1, table1, sel1, lu_a1, lu_b1);
        end
        checks++;
        if ({busy0, done0, step0, table0, busy3, done3, step3, table3} !== 78'd0) begin
            failures++;
            $display("FAIL reset_other: busy0=%b step0=%0d table0=%h busy3=%b step3=%0d table3=%h, want 0",
                     busy0, step0, table0, busy3, step3, table3);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_golden;
        int n, b;
        start_sweep1();
        checks++;
        if (busy1 !== 1'b1 || step1 !== 5'd0 || table1 !== 32'd0) begin
            failures++;
            $display("FAIL golden_start: busy=%b step=%0d table=%h, want 1/0/0", busy1, step1, table1);
        end
        wait_done1(n, b);
        checks++;
        if (n !== 64) begin
            failures++;
            $display("FAIL golden_latency: done at E0+%0d, want E0+64", n);
        end
        checks++;
        if (b !== 64) begin
            failures++;
            $display("FAIL golden_busy: busy cycles=%0d, want 64", b);
        end
        checks++;
        if (table1 !== c_gold || step1 !== 5'd31 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL golden_table: table=%h step=%0d busy=%b, want %h/31/0", table1, step1, busy1, c_gold);
        end
        tick();
        checks++;
        if (done1 !== 1'b0 || table1 !== c_gold || step1 !== 5'd31) begin
            failures++;
            $display("FAIL golden_after: done=%b table=%h step=%0d, want 0/%h/31", done1, table1, step1, c_gold);
        end
    endtask

    task automatic test_tied;
        int n, b, nd;
        logic [31:0] want;
        for (int m = 1; m <= 2; m++) begin
            lu_mode = m;
            want = (m == 2) ? 32'hFFFF_FFFF : 32'h0000_0000;
            start_sweep1();
            wait_done1(n, b);
            nd = (n > 0) ? 1 : 0;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (done1) nd++;
            end
            checks++;
            if (table1 !== want || n !== 64) begin
                failures++;
                $display("FAIL tied_%0d: table=%h latency=%0d, want %h/64", m, table1, n, want);
            end
            checks++;
            if (nd !== 1) begin
                failures++;
                $display("FAIL tied_done_%0d: done pulses=%0d, want 1", m, nd);
            end
        end
        lu_mode = 0;
    endtask

    task automatic test_abort;
        int n, nd;
        start_sweep1();
        wait_step1(5'd10, n);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        checks++;
        if (n !== 20 || busy1 !== 1'b0 || done1 !== 1'b0 || step1 !== 5'd10) begin
            failures++;
            $display("FAIL abort_state: reach=%0d busy=%b done=%b step=%0d, want 20/0/0/10",
                     n, busy1, done1, step1);
        end
        checks++;
        if (table1 !== (c_gold & 32'h0000_03FF)) begin
            failures++;
            $display("FAIL abort_table: table=%h, want %h", table1, c_gold & 32'h0000_03FF);
        end
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done1 || busy1) nd++;
        end
        checks++;
        if (nd !== 0) begin
            failures++;
            $display("FAIL abort_idle: busy/done seen %0d times, want 0", nd);
        end
    endtask

    task automatic test_start_ignored;
        int n, m, b;
        start_sweep1();
        checks++;
        if (table1 !== 32'd0) begin
            failures++;
            $display("FAIL restart_clear: table=%h, want 0", table1);
        end
        wait_step1(5'd5, n);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_done1(m, b);
        checks++;
        if (n !== 10 || n + 1 + m !== 64 || table1 !== c_gold) begin
            failures++;
            $display("FAIL start_in_drive: latency=%0d table=%h, want 64/%h", n + 1 + m, table1, c_gold);
        end
        tick();
        tick();
        tick();
        checks++;
        if (busy1 !== 1'b0) begin
            failures++;
            $display("FAIL start_queued: busy=%b, want 0", busy1);
        end
        start1 = 1'b1;
        abort1 = 1'b1;
        tick();
        start1 = 1'b0;
        abort1 = 1'b0;
        tick();
        checks++;
        if (busy1 !== 1'b0 || table1 !== c_gold || step1 !== 5'd31) begin
            failures++;
            $display("FAIL start_abort_idle: busy=%b table=%h step=%0d, want 0/%h/31", busy1, table1, step1, c_gold);
        end
    endtask

    task automatic test_reset_mid;
        int n, b;
        start_sweep1();
        wait_step1(5'd20, n);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (n !== 40 || {busy1, done1, step1, table1, sel1, lu_a1, lu_b1} !== 43'd0) begin
            failures++;
            $display("FAIL reset_mid: reach=%0d busy=%b done=%b step=%0d table=%h, want 40 and all 0",
                     n, busy1, done1, step1, table1);
        end
        tick();
        start_sweep1();
        wait_done1(n, b);
        checks++;
        if (n !== 64 || table1 !== c_gold) begin
            failures++;
            $display("FAIL reset_fresh: latency=%0d table=%h, want 64/%h", n, table1, c_gold);
        end
    endtask

    task automatic test_settle(input int s);
        int k, bad;
        logic [4:0] exp_step;
        logic [4:0] st;
        logic [2:0] sl;
        logic       a, b, dn;
        logic [31:0] tb_val;
        if (s == 0) start0 = 1'b1; else start3 = 1'b1;
        tick();
        start0 = 1'b0;
        start3 = 1'b0;
        k = 0;
        bad = 0;
        dn = (s == 0) ? done0 : done3;
        while (!dn && k < 600) begin
            exp_step = 5'(k / (s + 1));
            st = (s == 0) ? step0 : step3;
            sl = (s == 0) ? sel0 : sel3;
            a  = (s == 0) ? lu_a0 : lu_a3;
            b  = (s == 0) ? lu_b0 : lu_b3;
            if (st !== exp_step || sl !== exp_step[4:2] || a !== exp_step[1] || b !== exp_step[0]) bad++;
            tick();
            k++;
            dn = (s == 0) ? done0 : done3;
        end
        tb_val = (s == 0) ? table0 : table3;
        checks++;
        if (k !== 32 * (s + 1)) begin
            failures++;
            $display("FAIL settle%0d_latency: done at E0+%0d, want E0+%0d", s, k, 32 * (s + 1));
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL settle%0d_steps: %0d cycles with wrong step/lu_* (want step changes only on boundaries)", s, bad);
        end
        checks++;
        if (tb_val !== c_gold) begin
            failures++;
            $display("FAIL settle%0d_table: table=%h, want %h", s, tb_val, c_gold);
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_tied();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        test_settle(0);
        test_settle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
